game_tick_crash_ctrl: RTL and testbench
=======================================

// Module: game_tick_crash_ctrl
// PURPOSE
//  Game-side counterpart of the player block. Generates the game_tick pair the player
//  block consumes and judges collisions from player_position/jumping/ducking against the
//  current obstacle. Drives crash back to the player block and tracks the game life-cycle
//  from its game_start/game_over pulses. Also keeps the run score.
// PARAMETERS
//  PHYS_DIV    1000  clk cycles per physics tick (game_tick[0]); >=2
//  FRAME_MULT  4     physics ticks per frame tick (game_tick[1]); >=1
//  PLAYER_X    16    leftmost obstacle_x column occupied by the player
//  PLAYER_W    4     player width in columns
//  CACTUS_H    8     cactus hits when player_position < CACTUS_H
//  BIRD_LO     6     bird hits when !ducking && player_position >= BIRD_LO
//  CRASH_TMO   32    frame ticks to wait for game_over_pulse before forcing GAME_OVER
// PORTS
//  clk              in   1  clock
//  reset            in   1  synchronous, active-high reset
//  player_position  in   6  player height above ground, 0 = ground
//  jumping          in   1  player in jump arc
//  ducking          in   1  player ducking
//  game_start_pulse in   1  1-cycle start pulse from player block
//  game_over_pulse  in   1  1-cycle game-over pulse from player block
//  obstacle_valid   in   1  an obstacle is on screen
//  obstacle_x       in   8  obstacle column
//  obstacle_bird    in   1  1 = bird (high), 0 = cactus (ground)
//  game_tick        out  2  [0] physics tick, [1] frame tick; 1-cycle pulses
//  crash            out  1  level: collision detected, held until acknowledged
//  score            out  10 frames survived in current run, saturating
//  game_state       out  2  IDLE=0 RUNNING=1 CRASHED=2 GAME_OVER=3
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, dividers cleared; first physics tick PHYS_DIV
//   cycles after reset deasserts.
//  Ticks run in every state (player block needs them to animate/restart).
//   game_tick[0] high 1 cycle every PHYS_DIV clks. game_tick[1] coincides with every
//   FRAME_MULT-th game_tick[0], same cycle.
//  Hit = obstacle_valid && PLAYER_X <= obstacle_x <= PLAYER_X+PLAYER_W-1 (8-bit unsigned,
//   no wrap) && (bird ? (!ducking && pos>=BIRD_LO) : pos<CACTUS_H).
//  Hit is evaluated only in RUNNING and only on cycles with game_tick[0]=1. Inputs are
//   sampled that cycle; crash rises the next cycle (1-cycle latency).
//  FSM (registered; transitions on the clock edge):
//   IDLE:      game_start_pulse -> RUNNING; score<=0.
//   RUNNING:   game_over_pulse -> GAME_OVER. Else, physics-tick hit -> CRASHED, crash<=1.
//              If both occur in the same cycle, game_over_pulse wins (crash stays 0).
//              score += 1 on each frame tick; saturate at 1023.
//   CRASHED:   crash=1. Score frozen.
//              game_over_pulse -> GAME_OVER, crash<=0.
//              CRASH_TMO frame ticks without pulse -> GAME_OVER, crash<=0.
//   GAME_OVER: score held. game_start_pulse -> RUNNING, score<=0, timeout cleared.
//  game_start_pulse is ignored in RUNNING and CRASHED.
//  jumping is informational only; collision uses position, so a jump arc below CACTUS_H
//   still hits.
//  Reset mid-run: next cycle returns to IDLE, crash=0, score=0, tick phase restarts.
// STRUCTURE
//  Shared package game_pkg: game_state_t enum (IDLE/RUNNING/CRASHED/GAME_OVER) and
//   POS_W=6 / X_W=8 / SCORE_W=10 width constants, shared with the player and obstacle
//   blocks.
//  Sub-module tick_gen (PHYS_DIV, FRAME_MULT): produces game_tick[1:0].
//  Collision compare and FSM/score live in this module.
// TESTING
//  1 Reset, PHYS_DIV=4, FRAME_MULT=2:
//     game_tick[0] at cycles 4,8,12,...; game_tick[1] at 8,16,...; outputs 0 before that.
//  2 Start pulse, cactus at x=17, pos=0, on a physics tick:
//     crash=1 the next cycle, state=CRASHED; score frozen.
//  3 Same setup as 2 with pos=10, then bird at x=16 with ducking=1, pos=0:
//     no crash; score increments once per frame tick.
//  4 CRASHED, no game_over_pulse:
//     after exactly CRASH_TMO frame ticks, state=GAME_OVER and crash=0.
//  5 RUNNING, hit and game_over_pulse in the same cycle:
//     state=GAME_OVER, crash stays 0.
//  6 Force score to 1023 -> stays 1023. Reset mid-CRASHED -> IDLE, crash=0, score=0
//     next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-wide types and widths used by the player, obstacle and tick/crash blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUNNING   = 2'd1,
        CRASHED   = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int POS_W   = 6;
    localparam int X_W     = 8;
    localparam int SCORE_W = 10;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    // Inclusive column span test on the unsigned obstacle column; never wraps.
    function automatic logic x_in_span(input logic [X_W-1:0] x, input int lo, input int w);
        int xi;
        xi = int'(x);
        return (xi >= lo) && (xi <= lo + w - 1);
    endfunction

endpackage

// File: rtl/game_tick_crash_ctrl_if.sv
// Bundle between the player/obstacle side and the game tick/crash controller.
interface game_tick_crash_ctrl_if;
    import game_pkg::*;

    logic [POS_W-1:0]   player_position;
    logic               jumping;
    logic               ducking;
    logic               game_start_pulse;
    logic               game_over_pulse;
    logic               obstacle_valid;
    logic [X_W-1:0]     obstacle_x;
    logic               obstacle_bird;
    logic [1:0]         game_tick;
    logic               crash;
    logic [SCORE_W-1:0] score;
    logic [1:0]         game_state;

    modport master (
        output player_position, jumping, ducking, game_start_pulse, game_over_pulse,
               obstacle_valid, obstacle_x, obstacle_bird,
        input  game_tick, crash, score, game_state
    );

    modport slave (
        input  player_position, jumping, ducking, game_start_pulse, game_over_pulse,
               obstacle_valid, obstacle_x, obstacle_bird,
        output game_tick, crash, score, game_state
    );

endinterface

// File: rtl/tick_gen.sv
// Physics/frame tick divider; both ticks are registered 1-cycle pulses and the frame
// tick lands on the same cycle as every FRAME_MULT-th physics tick.
module tick_gen #(
    parameter int PHYS_DIV   = 1000,
    parameter int FRAME_MULT = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [1:0] o_tick
);

    localparam int PW = $clog2(PHYS_DIV);
    localparam int FW = (FRAME_MULT > 1) ? $clog2(FRAME_MULT) : 1;
    localparam logic [PW-1:0] PHYS_LAST  = PW'(PHYS_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_MULT - 1);

    logic [PW-1:0] r_phys_cnt;
    logic [FW-1:0] r_frame_cnt;
    logic [1:0]    r_tick;
    logic          w_phys_wrap;

    assign w_phys_wrap = (r_phys_cnt == PHYS_LAST);
    assign o_tick      = r_tick;

    // Divider counters and registered tick pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phys_cnt  <= '0;
            r_frame_cnt <= '0;
            r_tick      <= 2'b00;
        end else begin
            r_tick <= {w_phys_wrap && (r_frame_cnt == FRAME_LAST), w_phys_wrap};
            if (w_phys_wrap) begin
                r_phys_cnt  <= '0;
                r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
            end else begin
                r_phys_cnt  <= r_phys_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_tick_crash_ctrl.sv
// Game-side tick source, collision judge and life-cycle/score FSM paired with the
// player block.
module game_tick_crash_ctrl
    import game_pkg::*;
#(
    parameter int PHYS_DIV   = 1000,
    parameter int FRAME_MULT = 4,
    parameter int PLAYER_X   = 16,
    parameter int PLAYER_W   = 4,
    parameter int CACTUS_H   = 8,
    parameter int BIRD_LO    = 6,
    parameter int CRASH_TMO  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    game_tick_crash_ctrl_if.slave bus
);

    localparam int TW = $clog2(CRASH_TMO + 1);
    localparam logic [TW-1:0]    TMO_LAST   = TW'(CRASH_TMO - 1);
    localparam logic [POS_W-1:0] CACTUS_LIM = POS_W'(CACTUS_H);
    localparam logic [POS_W-1:0] BIRD_LIM   = POS_W'(BIRD_LO);

    logic [1:0]         w_tick;
    logic               w_pos_hit;
    logic               w_hit;
    logic               w_unused_jumping;

    game_state_t        r_state,  w_state_nxt;
    logic               r_crash,  w_crash_nxt;
    logic [SCORE_W-1:0] r_score,  w_score_nxt;
    logic [TW-1:0]      r_tmo,    w_tmo_nxt;

    tick_gen #(
        .PHYS_DIV   (PHYS_DIV),
        .FRAME_MULT (FRAME_MULT)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // Collision uses height only; the jump flag carries no extra meaning here.
    assign w_unused_jumping = bus.jumping;
    assign w_pos_hit = bus.obstacle_bird ? (!bus.ducking && (bus.player_position >= BIRD_LIM))
                                         : (bus.player_position < CACTUS_LIM);
    assign w_hit     = bus.obstacle_valid && x_in_span(bus.obstacle_x, PLAYER_X, PLAYER_W)
                       && w_pos_hit;

    assign bus.game_tick  = w_tick;
    assign bus.crash      = r_crash;
    assign bus.score      = r_score;
    assign bus.game_state = r_state;

    // Next-state, crash, score and timeout logic.
    always_comb begin
        w_state_nxt = r_state;
        w_crash_nxt = r_crash;
        w_score_nxt = r_score;
        w_tmo_nxt   = '0;
        case (r_state)
            IDLE: begin
                w_crash_nxt = 1'b0;
                if (bus.game_start_pulse) begin
                    w_state_nxt = RUNNING;
                    w_score_nxt = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUNNING: begin
                w_crash_nxt = 1'b0;
                if (w_tick[1] && (r_score != SCORE_MAX)) begin
                    w_score_nxt = r_score + 1'b1;
                end else begin
                    w_score_nxt = r_score;
                end
                // An explicit game-over outranks a simultaneous hit.
                if (bus.game_over_pulse) begin
                    w_state_nxt = GAME_OVER;
                end else if (w_tick[0] && w_hit) begin
                    w_state_nxt = CRASHED;
                    w_crash_nxt = 1'b1;
                end else begin
                    w_state_nxt = RUNNING;
                end
            end
            CRASHED: begin
                w_crash_nxt = 1'b1;
                w_tmo_nxt   = r_tmo;
                if (bus.game_over_pulse) begin
                    w_state_nxt = GAME_OVER;
                    w_crash_nxt = 1'b0;
                end else if (w_tick[1]) begin
                    if (r_tmo == TMO_LAST) begin
                        w_state_nxt = GAME_OVER;
                        w_crash_nxt = 1'b0;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end else begin
                    w_state_nxt = CRASHED;
                end
            end
            GAME_OVER: begin
                w_crash_nxt = 1'b0;
                if (bus.game_start_pulse) begin
                    w_state_nxt = RUNNING;
                    w_score_nxt = '0;
                end else begin
                    w_state_nxt = GAME_OVER;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_crash_nxt = 1'b0;
                w_score_nxt = '0;
            end
        endcase
    end

    // FSM, crash, score and timeout registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_crash <= 1'b0;
            r_score <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_crash <= w_crash_nxt;
            r_score <= w_score_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

endmodule

// File: tb/tb_game_tick_crash_ctrl.sv
// Scenario bench for game_tick_crash_ctrl: expected tick/state/crash/score per cycle are
// queued as stimulus is applied and compared one cycle later.
module tb_game_tick_crash_ctrl;
    import game_pkg::*;

    typedef struct packed {
        logic [1:0] tick;
        logic [1:0] st;
        logic       crash;
        logic [9:0] score;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    game_tick_crash_ctrl_if bus();

    game_tick_crash_ctrl #(
        .PHYS_DIV   (4),
        .FRAME_MULT (2),
        .PLAYER_X   (16),
        .PLAYER_W   (4),
        .CACTUS_H   (8),
        .BIRD_LO    (6),
        .CRASH_TMO  (3)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Cycles since reset released: physics ticks at multiples of 4, frames at multiples of 8.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic exp_t mk(input int c, input logic [1:0] st, input logic cr, input int sc);
        exp_t e;
        e.tick  = {(c != 0) && (c % 8 == 0), (c != 0) && (c % 4 == 0)};
        e.st    = st;
        e.crash = cr;
        e.score = 10'((sc > 1023) ? 1023 : sc);
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_obs(input logic v, input logic [7:0] x, input logic bird,
                           input logic [5:0] pos, input logic duck, input logic jump);
        bus.obstacle_valid  = v;
        bus.obstacle_x      = x;
        bus.obstacle_bird   = bird;
        bus.player_position = pos;
        bus.ducking         = duck;
        bus.jumping         = jump;
    endtask

    task automatic test_reset;
        exp_t e;
        logic [14:0] obs;
        reset = 1'b1;
        bus.game_start_pulse = 1'b0;
        bus.game_over_pulse  = 1'b0;
        set_obs(1'b0, 8'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 15'd0);
        end
        for (int k = 1; k <= 16; k++) sb_q.push_back(mk(k, 2'd0, 1'b0, 0));
        for (int k = 1; k <= 16; k++) begin
            step();
            e   = sb_q.pop_front();
            obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_ticks cyc=%0d got=%h want=%h", cyc, obs, e);
            end
        end
    endtask

    // Cactus at x=17 while jumping at height 5: still a hit; start ignored once crashed.
    task automatic test_cactus_crash;
        exp_t e;
        logic [14:0] obs;
        int c;
        set_obs(1'b1, 8'd17, 1'b0, 6'd5, 1'b0, 1'b1);
        while (cyc < 26) begin
            c = cyc + 1;
            bus.game_start_pulse = (cyc == 16) || (cyc == 22);
            sb_q.push_back(mk(c, (c >= 21) ? 2'd2 : 2'd1, c >= 21, 0));
            step();
            bus.game_start_pulse = 1'b0;
            e   = sb_q.pop_front();
            obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL cactus_crash cyc=%0d got=%h want=%h", cyc, obs, e);
            end
        end
        bus.game_over_pulse = 1'b1;
        sb_q.push_back(mk(cyc + 1, 2'd3, 1'b0, 0));
        step();
        bus.game_over_pulse = 1'b0;
        e   = sb_q.pop_front();
        obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL over_pulse cyc=%0d got=%h want=%h", cyc, obs, e);
        end
    endtask

    // Cactus cleared by height, then bird dodged by ducking; score counts frames.
    task automatic test_no_crash;
        exp_t e;
        logic [14:0] obs;
        int c;
        set_obs(1'b1, 8'd17, 1'b0, 6'd10, 1'b0, 1'b0);
        while (cyc < 57) begin
            c = cyc + 1;
            bus.game_start_pulse = (cyc == 27);
            if (cyc >= 40) set_obs(1'b1, 8'd16, 1'b1, 6'd0, 1'b1, 1'b0);
            sb_q.push_back(mk(c, 2'd1, 1'b0, (c - 1) / 8 - 3));
            step();
            bus.game_start_pulse = 1'b0;
            e   = sb_q.pop_front();
            obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL no_crash cyc=%0d got=%h want=%h", cyc, obs, e);
            end
        end
    endtask

    // Upright bird at x=19 hits at height 7; no game-over pulse, so timeout ends the run.
    task automatic test_timeout;
        exp_t e;
        logic [14:0] obs;
        int c;
        logic [1:0] st;
        set_obs(1'b1, 8'd19, 1'b1, 6'd7, 1'b0, 1'b0);
        while (cyc < 83) begin
            c  = cyc + 1;
            st = (c <= 60) ? 2'd1 : ((c <= 80) ? 2'd2 : 2'd3);
            sb_q.push_back(mk(c, st, st == 2'd2, 4));
            step();
            e   = sb_q.pop_front();
            obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL crash_timeout cyc=%0d got=%h want=%h", cyc, obs, e);
            end
        end
    endtask

    // Hit and game-over pulse on the same physics tick: game over wins, crash stays low.
    task automatic test_hit_and_over;
        exp_t e;
        logic [14:0] obs;
        int c;
        set_obs(1'b1, 8'd16, 1'b0, 6'd3, 1'b0, 1'b0);
        while (cyc < 87) begin
            c = cyc + 1;
            bus.game_start_pulse = (cyc == 83);
            bus.game_over_pulse  = (cyc == 84);
            sb_q.push_back(mk(c, (c == 84) ? 2'd1 : 2'd3, 1'b0, 0));
            step();
            bus.game_start_pulse = 1'b0;
            bus.game_over_pulse  = 1'b0;
            e   = sb_q.pop_front();
            obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL hit_and_over cyc=%0d got=%h want=%h", cyc, obs, e);
            end
        end
    endtask

    // Run long enough to saturate the score, crash, then reset mid-CRASHED.
    task automatic test_saturate_reset;
        exp_t e;
        logic [14:0] obs;
        int c;
        set_obs(1'b0, 8'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        while (cyc < 8303) begin
            c = cyc + 1;
            bus.game_start_pulse = (cyc == 87);
            if (cyc == 8300) set_obs(1'b1, 8'd18, 1'b0, 6'd0, 1'b0, 1'b0);
            sb_q.push_back(mk(c, (c >= 8301) ? 2'd2 : 2'd1, c >= 8301, (c - 1) / 8 - 10));
            step();
            bus.game_start_pulse = 1'b0;
            e   = sb_q.pop_front();
            obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL saturate cyc=%0d got=%h want=%h", cyc, obs, e);
            end
        end
        reset = 1'b1;
        sb_q.push_back(mk(0, 2'd0, 1'b0, 0));
        step();
        reset = 1'b0;
        set_obs(1'b0, 8'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        e   = sb_q.pop_front();
        obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_crash got=%h want=%h", obs, e);
        end
        for (int k = 1; k <= 8; k++) begin
            sb_q.push_back(mk(k, 2'd0, 1'b0, 0));
            step();
            e   = sb_q.pop_front();
            obs = {bus.game_tick, bus.game_state, bus.crash, bus.score};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL tick_restart cyc=%0d got=%h want=%h", cyc, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cactus_crash();
        test_no_crash();
        test_timeout();
        test_hit_and_over();
        test_saturate_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
